io_switch_debouncer: RTL and testbench

//   Input-side stage that conditions the board slide switches before the

---
 rtl/io_switch_debouncer.sv | 116 +++++++++++
 tb/tb_io_switch_debouncer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_switch_debouncer.sv
// rtl/io_switch_debouncer.sv - per-bit two-flop synchronizer and debounce FSM for board slide switches
// Optional DEBOUNCE_BYPASS_EN: removes counters/FSM so the synchronized level is registered directly.
module io_switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PORT_SPLIT      = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed,
    output logic [31:0]      in_port0,
    output logic [31:0]      in_port1
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] changed_q, changed_d;

    always_comb begin
        s1_d = sw_raw;
        s2_d = s1_q;
    end

`ifdef DEBOUNCE_BYPASS_EN

    always_comb begin
        stable_d  = s2_q;
        changed_d = s2_q ^ stable_q;
    end

`else

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } bit_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    bit_state_t       state_q [WIDTH];
    bit_state_t       state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    // Counter is compared before incrementing, so it never exceeds CNT_LAST.
    always_comb begin
        stable_d  = stable_q;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == ST_STABLE) begin
                if (s2_q[i] != stable_q[i]) begin
                    cnt_d[i]   = CNT_W'(1);
                    state_d[i] = ST_SETTLING;
                end else begin
                    cnt_d[i]   = '0;
                end
            end else begin
                if (s2_q[i] == stable_q[i]) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_STABLE;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i]  = s2_q[i];
                    changed_d[i] = 1'b1;
                    cnt_d[i]     = '0;
                    state_d[i]   = ST_STABLE;
                end else begin
                    cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            changed_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    // Port slices are combinational so the CPU sees sw_stable with no added delay.
    assign sw_stable  = stable_q;
    assign sw_changed = changed_q;
    assign in_port0   = 32'(stable_q[PORT_SPLIT-1:0]);
    assign in_port1   = 32'(stable_q[WIDTH-1:PORT_SPLIT]);

endmodule

// File: tb/tb_io_switch_debouncer.sv
// tb/tb_io_switch_debouncer.sv - self-checking bench for io_switch_debouncer with a sliding-window reference model
module tb_io_switch_debouncer;

    localparam int WIDTH = 10;
    localparam int SPLIT = 5;
`ifdef DEBOUNCE_BYPASS_EN
    localparam int MD = 1;
`else
    localparam int MD = 4;
`endif
    localparam int LAT = MD + 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_changed;
    logic [31:0]      in_port0;
    logic [31:0]      in_port1;

    io_switch_debouncer #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(4),
        .PORT_SPLIT(SPLIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_changed(sw_changed),
        .in_port0(in_port0),
        .in_port1(in_port1)
    );

    always #5 clock = ~clock;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: raw samples per edge; the filter sees the sample from two edges back,
    // and a bit flips once its last MD filter inputs all disagree with the stable value.
    logic [WIDTH-1:0] raw_hist[$];
    logic [WIDTH-1:0] seen_hist[$];
    logic [WIDTH-1:0] m_stable;
    logic [WIDTH-1:0] m_changed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        raw_hist.delete();
        seen_hist.delete();
        m_stable  = '0;
        m_changed = '0;
    endtask

    task automatic check_model();
        check("stable", 32'(sw_stable), 32'(m_stable));
        check("changed", 32'(sw_changed), 32'(m_changed));
        check("in_port0", in_port0, 32'(m_stable[SPLIT-1:0]));
        check("in_port1", in_port1, 32'(m_stable[WIDTH-1:SPLIT]));
    endtask

    task automatic step();
        logic [WIDTH-1:0] seen;
        bit all_diff;
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            raw_hist.push_back(sw_raw);
            if (raw_hist.size() > 8) void'(raw_hist.pop_front());
            seen = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : '0;
            seen_hist.push_back(seen);
            if (seen_hist.size() > 8) void'(seen_hist.pop_front());
            m_changed = '0;
            for (int i = 0; i < WIDTH; i++) begin
                all_diff = (seen_hist.size() >= MD);
                for (int k = 0; k < MD && all_diff; k++)
                    if (seen_hist[seen_hist.size()-1-k][i] == m_stable[i]) all_diff = 0;
                if (all_diff) begin
                    m_stable[i]  = ~m_stable[i];
                    m_changed[i] = 1'b1;
                end
            end
        end
        #1;
        check_model();
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b1;
        #1;
        model_clear();
        check_model();
        repeat (edges) step();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [WIDTH-1:0] mask;
        reset  = 1'b1;
        sw_raw = '0;
        #1;
        model_clear();
        check_model();
        repeat (2) step();
        reset = 1'b0;

        // 1: reset in the middle of settling restarts the filter
        sw_raw = 10'h3FF;
        repeat (3) step();
        do_reset(2);
        repeat (LAT - 1) step();
        check("t1_before", 32'(sw_stable), 32'h0);
        step();
        check("t1_after", 32'(sw_stable), 32'h3FF);
        check("t1_pulse", 32'(sw_changed), 32'h3FF);

        // 2: two bits across both ports
        do_reset(1);
        sw_raw = 10'b0000100001;
        repeat (LAT - 1) step();
        check("t2_before", 32'(sw_stable), 32'h0);
        step();
        check("t2_stable", 32'(sw_stable), 32'h021);
        check("t2_pulse", 32'(sw_changed), 32'h021);
        check("t2_port0", in_port0, 32'h1);
        check("t2_port1", in_port1, 32'h1);
        step();
        check("t2_pulse_end", 32'(sw_changed), 32'h0);

        // 3: short glitch on bit0
        do_reset(1);
        pulses = 0;
        sw_raw = 10'h001;
        repeat (3) begin step(); pulses += int'(sw_changed[0]); end
        sw_raw = 10'h000;
        repeat (10) begin step(); pulses += int'(sw_changed[0]); end
`ifndef DEBOUNCE_BYPASS_EN
        check("t3_stable", 32'(sw_stable), 32'h0);
        check("t3_pulses", 32'(pulses), 32'd0);
`endif

        // 4: bounce on bit3 before a steady high level
        pulses = 0;
        sw_raw = 10'h008; step(); pulses += int'(sw_changed[3]);
        sw_raw = 10'h000; step(); pulses += int'(sw_changed[3]);
        sw_raw = 10'h008;
        repeat (LAT - 1) begin step(); pulses += int'(sw_changed[3]); end
        check("t4_before", 32'(sw_stable[3]), 32'h0);
        step(); pulses += int'(sw_changed[3]);
        check("t4_after", 32'(sw_stable[3]), 32'h1);
        repeat (6) begin step(); pulses += int'(sw_changed[3]); end
`ifndef DEBOUNCE_BYPASS_EN
        check("t4_pulses", 32'(pulses), 32'd1);
`endif

        // 5: simultaneous change at both ends of the vector
        do_reset(1);
        sw_raw = 10'h201;
        repeat (LAT) step();
        check("t5_pulse", 32'(sw_changed), 32'h201);
        check("t5_port1_4", 32'(in_port1[4]), 32'h1);
        check("t5_port0_0", 32'(in_port0[0]), 32'h1);

`ifdef DEBOUNCE_BYPASS_EN
        // 6: bypass latency
        do_reset(1);
        sw_raw = 10'h155;
        repeat (2) step();
        check("t6_before", 32'(sw_stable), 32'h0);
        step();
        check("t6_stable", 32'(sw_stable), 32'h155);
        check("t6_pulse", 32'(sw_changed), 32'h155);
`endif

        // random bit toggling against the model, with one reset in the middle
        for (int n = 0; n < 400; n++) begin
            mask = '0;
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 5) == 0) mask[b] = 1'b1;
            sw_raw = sw_raw ^ mask;
            if (n == 200) do_reset(1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
